btn_conditioner: RTL and testbench



---
 rtl/btn_pkg.sv | 9 +
 rtl/btn_conditioner_if.sv | 14 +
 rtl/btn_debounce_ch.sv | 60 ++++++
 rtl/btn_conditioner.sv | 27 ++
 tb/tb_btn_conditioner.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/btn_pkg.sv
// btn_pkg: shared defaults, button vector type and board bit mapping for btn_conditioner
package btn_pkg;
  localparam int BTN_DEBOUNCE_DEFAULT = 1_000_000;
  localparam int BTN_LONG_DEFAULT = 100_000_000;
  typedef logic [2:0] btn_vec_t;
  localparam int BTN_CLEAR = 0;
  localparam int BTN_START = 1;
  localparam int BTN_STOP = 2;
endpackage

// File: rtl/btn_conditioner_if.sv
// btn_conditioner_if: raw button levels in, conditioned level/press/release/long vectors out
interface btn_conditioner_if
  import btn_pkg::*;
#(
  parameter int N_BTN = $bits(btn_vec_t)
);
  logic [N_BTN-1:0] btn_i;
  logic [N_BTN-1:0] level_o;
  logic [N_BTN-1:0] press_o;
  logic [N_BTN-1:0] release_o;
  logic [N_BTN-1:0] long_o;
  modport master (output btn_i, input level_o, press_o, release_o, long_o);
  modport slave (input btn_i, output level_o, press_o, release_o, long_o);
endinterface

// File: rtl/btn_debounce_ch.sv
// btn_debounce_ch: one button channel (sync, debounce, edge pulses; long-press pulse with BTN_LONG_PRESS_EN)
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEFAULT,
  parameter int LONG_CYCLES = BTN_LONG_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic press,
  output logic lift,
  output logic long_hit
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_cfg
    $error("btn_debounce_ch: need DEBOUNCE_CYCLES >= 2 and LONG_CYCLES > DEBOUNCE_CYCLES");
  end
  logic [1:0] sync_ff;
  logic [CW-1:0] cnt;
  logic sync;
  logic accept;
  logic fall;
  assign sync = sync_ff[1];
  assign accept = (sync != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign fall = accept && level;
  // synchronise, count consecutive disagreeing cycles, flip the level after a full stable run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff <= '0;
      cnt <= '0;
      level <= 1'b0;
      press <= 1'b0;
      lift <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[0], btn};
      cnt <= (sync == level || accept) ? '0 : cnt + 1'b1;
      level <= accept ? sync : level;
      press <= accept && sync;
      lift <= fall;
    end
  end
`ifdef BTN_LONG_PRESS_EN
  localparam int HW = $clog2(LONG_CYCLES + 1);
  logic [HW-1:0] hold;
  // saturating hold counter while the level is high; pulse on the step into LONG_CYCLES
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold <= '0;
      long_hit <= 1'b0;
    end else begin
      hold <= fall ? '0 : (level && hold != HW'(LONG_CYCLES)) ? hold + 1'b1 : hold;
      long_hit <= level && !fall && hold == HW'(LONG_CYCLES - 1);
    end
  end
`else
  assign long_hit = 1'b0;
`endif
endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: N independent debounced button channels; long-press pulses need BTN_LONG_PRESS_EN
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN = $bits(btn_vec_t),
  parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEFAULT,
  parameter int LONG_CYCLES = BTN_LONG_DEFAULT
) (
  input logic clk,
  input logic rst_n,
  btn_conditioner_if.slave bus
);
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES(LONG_CYCLES)
    ) u_ch (
      .clk(clk),
      .rst_n(rst_n),
      .btn(bus.btn_i[i]),
      .level(bus.level_o[i]),
      .press(bus.press_o[i]),
      .lift(bus.release_o[i]),
      .long_hit(bus.long_o[i])
    );
  end
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed and random checks of btn_conditioner against a sliding-window model
module tb_btn_conditioner;
  import btn_pkg::*;
  localparam int N = 3;
  localparam int D = 4;
  localparam int L = 10;
`ifdef BTN_LONG_PRESS_EN
  localparam bit LONG_ON = 1'b1;
`else
  localparam bit LONG_ON = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  btn_conditioner_if #(.N_BTN(N)) bus ();
  btn_conditioner #(.N_BTN(N), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  // model: win[i] is the raw vector sampled i edges ago; a level flips when the D
  // samples that have passed through the two-flop synchroniser all disagree with it
  logic [N-1:0] win [D+2];
  logic [N-1:0] m_level, m_press, m_release, m_long;
  int age [N];
  task automatic model_reset();
    for (int i = 0; i < D + 2; i++) win[i] = '0;
    m_level = '0;
    m_press = '0;
    m_release = '0;
    m_long = '0;
    for (int c = 0; c < N; c++) age[c] = 0;
  endtask
  task automatic model_step();
    bit moved;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int i = D + 1; i > 0; i--) win[i] = win[i-1];
    win[0] = bus.btn_i;
    m_press = '0;
    m_release = '0;
    m_long = '0;
    for (int c = 0; c < N; c++) begin
      moved = 1'b1;
      for (int i = 2; i <= D + 1; i++) if (win[i][c] == m_level[c]) moved = 1'b0;
      if (moved) begin
        m_level[c] = ~m_level[c];
        m_press[c] = m_level[c];
        m_release[c] = ~m_level[c];
      end
      if (m_press[c] || !m_level[c]) age[c] = 0;
      else if (age[c] <= L) age[c]++;
      m_long[c] = LONG_ON && m_level[c] && !m_press[c] && age[c] == L;
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    total++;
    if ({bus.level_o, bus.press_o, bus.release_o, bus.long_o} !== {m_level, m_press, m_release, m_long}) begin
      bad++;
      $display("FAIL model t=%0t level/press/release/long got %b/%b/%b/%b want %b/%b/%b/%b", $time,
               bus.level_o, bus.press_o, bus.release_o, bus.long_o, m_level, m_press, m_release, m_long);
    end
  endtask
  task automatic test_reset();
    bus.btn_i = '1;
    rst_n = 1'b0;
    model_reset();
    repeat (3) tick();
    total++;
    if ({bus.level_o, bus.press_o, bus.release_o, bus.long_o} !== '0) begin
      bad++;
      $display("FAIL reset_hold got %b want 0", {bus.level_o, bus.press_o, bus.release_o, bus.long_o});
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      total++;
      if (bus.press_o !== (i == 6 ? 3'b111 : 3'b000) || bus.level_o !== (i >= 6 ? 3'b111 : 3'b000)) begin
        bad++;
        $display("FAIL reset_release cycle %0d press/level got %b/%b want %b/%b", i, bus.press_o, bus.level_o,
                 i == 6 ? 3'b111 : 3'b000, i >= 6 ? 3'b111 : 3'b000);
      end
    end
  endtask
  task automatic test_clean_press();
    bus.btn_i = '0;
    repeat (10) tick();
    bus.btn_i[BTN_START] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      total++;
      if (bus.press_o[BTN_START] !== (i == 6) || bus.level_o[BTN_START] !== (i >= 6)) begin
        bad++;
        $display("FAIL clean_press cycle %0d press/level got %b/%b want %b/%b", i,
                 bus.press_o[BTN_START], bus.level_o[BTN_START], i == 6, i >= 6);
      end
    end
  endtask
  task automatic test_bounce();
    for (int p = 0; p < 4; p++) begin
      bus.btn_i[BTN_CLEAR] = (p % 2 == 0);
      repeat (2) begin
        tick();
        total++;
        if (bus.press_o !== '0 || bus.release_o !== '0 || bus.level_o[BTN_CLEAR] !== 1'b0) begin
          bad++;
          $display("FAIL bounce_quiet press/release/level0 got %b/%b/%b want 000/000/0", bus.press_o,
                   bus.release_o, bus.level_o[BTN_CLEAR]);
        end
      end
    end
    bus.btn_i[BTN_CLEAR] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      total++;
      if (bus.level_o[BTN_CLEAR] !== (i >= 6) || bus.press_o[BTN_CLEAR] !== (i == 6)) begin
        bad++;
        $display("FAIL bounce_settle cycle %0d level/press got %b/%b want %b/%b", i,
                 bus.level_o[BTN_CLEAR], bus.press_o[BTN_CLEAR], i >= 6, i == 6);
      end
    end
  endtask
  task automatic test_glitch();
    bus.btn_i[BTN_STOP] = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      if (i == 4) bus.btn_i[BTN_STOP] = 1'b0;
      tick();
      total++;
      if ({bus.level_o[BTN_STOP], bus.press_o[BTN_STOP], bus.release_o[BTN_STOP]} !== 3'b000) begin
        bad++;
        $display("FAIL glitch cycle %0d level/press/release got %b want 000", i,
                 {bus.level_o[BTN_STOP], bus.press_o[BTN_STOP], bus.release_o[BTN_STOP]});
      end
    end
  endtask
  task automatic test_simultaneous();
    bus.btn_i = '0;
    repeat (10) tick();
    bus.btn_i = 3'b101;
    for (int i = 1; i <= 26; i++) begin
      tick();
      total++;
      if (bus.press_o !== (i == 6 ? 3'b101 : 3'b000) || bus.release_o !== (i == 26 ? 3'b001 : 3'b000)) begin
        bad++;
        $display("FAIL simultaneous cycle %0d press/release got %b/%b want %b/%b", i, bus.press_o,
                 bus.release_o, i == 6 ? 3'b101 : 3'b000, i == 26 ? 3'b001 : 3'b000);
      end
      if (i == 20) bus.btn_i[BTN_CLEAR] = 1'b0;
    end
    bus.btn_i = 3'b010;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if ({bus.level_o, bus.press_o, bus.release_o, bus.long_o} !== '0) begin
      bad++;
      $display("FAIL async_reset got %b want 0", {bus.level_o, bus.press_o, bus.release_o, bus.long_o});
    end
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      total++;
      if (bus.press_o !== (i == 6 ? 3'b010 : 3'b000)) begin
        bad++;
        $display("FAIL reset_restart cycle %0d press got %b want %b", i, bus.press_o, i == 6 ? 3'b010 : 3'b000);
      end
    end
  endtask
  task automatic test_long();
    int rise_i = 0, long_i = 0, long_n = 0, rel_i = 0;
    bus.btn_i = '0;
    repeat (10) tick();
    bus.btn_i[BTN_START] = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (bus.press_o[BTN_START] && rise_i == 0) rise_i = i;
      if (bus.long_o[BTN_START]) begin
        long_n++;
        long_i = i;
      end
      if (bus.release_o[BTN_START] && rel_i == 0) rel_i = i;
      if (i == 30) bus.btn_i[BTN_START] = 1'b0;
    end
    total++;
    if (rise_i != 6 || rel_i != 36) begin
      bad++;
      $display("FAIL long_edges rise/release cycle got %0d/%0d want 6/36", rise_i, rel_i);
    end
    total++;
    if (long_n != (LONG_ON ? 1 : 0) || (LONG_ON && long_i != rise_i + L)) begin
      bad++;
      $display("FAIL long_pulse count/cycle got %0d/%0d want %0d/%0d", long_n, long_i, LONG_ON ? 1 : 0,
               LONG_ON ? rise_i + L : 0);
    end
  endtask
  task automatic test_random();
    int hold [N];
    for (int c = 0; c < N; c++) hold[c] = 0;
    for (int t = 0; t < 600; t++) begin
      for (int c = 0; c < N; c++) begin
        if (hold[c] == 0) begin
          bus.btn_i[c] = 1'($urandom_range(0, 1));
          hold[c] = $urandom_range(1, 24);
        end
        hold[c]--;
      end
      tick();
    end
  endtask
  initial begin
    bus.btn_i = '0;
    model_reset();
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_simultaneous();
    test_long();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
